// File: rtl/td4_disp_pkg.sv
// Shared types and constants for the TD4 register-display scanner.
package td4_disp_pkg;

    typedef enum logic [1:0] {
        ST_SEL,
        ST_CAP,
        ST_EMIT,
        ST_IDLE
    } state_t;

    localparam int NUM_FIELDS      = 6;
    localparam int FIELDS_PER_LINE = 3;

    localparam logic [6:0] LINE0_BASE = 7'h00;
    localparam logic [6:0] LINE1_BASE = 7'h40;

    localparam logic [7:0] SPACE_CODE = 8'h20;

    localparam logic [7:0] LBL_PC  = 8'h50;
    localparam logic [7:0] LBL_A   = 8'h41;
    localparam logic [7:0] LBL_B   = 8'h42;
    localparam logic [7:0] LBL_C   = 8'h43;
    localparam logic [7:0] LBL_OUT = 8'h4F;
    localparam logic [7:0] LBL_IN  = 8'h49;

    function automatic logic [7:0] label_char(input logic [2:0] fld);
        case (fld)
            3'd0:    label_char = LBL_PC;
            3'd1:    label_char = LBL_A;
            3'd2:    label_char = LBL_B;
            3'd3:    label_char = LBL_C;
            3'd4:    label_char = LBL_OUT;
            default: label_char = LBL_IN;
        endcase
    endfunction

endpackage

// File: rtl/td4_hex2ascii.sv
// Combinational nibble to uppercase ASCII hex digit.
module td4_hex2ascii (
    input  logic [3:0] nib,
    output logic [7:0] code
);

    always_comb begin
        if (nib < 4'd10) code = 8'h30 + {4'h0, nib};
        else             code = 8'h37 + {4'h0, nib};
    end

endmodule

// File: rtl/td4_reg_display.sv
// Scans the TD4 debug mux (PC, A, B, C, OUT, IN) and writes hex fields to the LCD.
// Define TD4_DISP_LABEL_EN to prefix each field with a one-letter label.
module td4_reg_display
    import td4_disp_pkg::*;
#(
    parameter int REFRESH_DIV = 1000000
) (
    input  logic       CLOCK,
    input  logic       RESET,
    output logic [2:0] regsel,
    input  logic [7:0] regdat,
    output logic       char_valid,
    input  logic       char_ready,
    output logic [6:0] char_addr,
    output logic [7:0] char_code,
    output logic       frame_done
);

`ifdef TD4_DISP_LABEL_EN
    localparam int FIELD_W = 4;
`else
    localparam int FIELD_W = 3;
`endif
    localparam logic [1:0] LAST_IDX   = 2'(FIELD_W - 1);
    localparam logic [2:0] LAST_FIELD = 3'(NUM_FIELDS - 1);
    localparam logic [2:0] LINE_SPLIT = 3'(FIELDS_PER_LINE);

    state_t      state, state_nx;
    logic [2:0]  k;
    logic [1:0]  idx;
    logic [7:0]  cap;
    logic [23:0] idle_cnt;
    logic [7:0]  hi_code, lo_code;
    logic        accept, last_chr, idle_done, line1;
    logic [2:0]  slot;

    td4_hex2ascii u_hi (.nib(cap[7:4]), .code(hi_code));
    td4_hex2ascii u_lo (.nib(cap[3:0]), .code(lo_code));

    assign accept    = char_valid & char_ready;
    assign last_chr  = (idx == LAST_IDX);
    assign idle_done = (idle_cnt == 24'(REFRESH_DIV - 1));

    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            state    <= ST_SEL;
            k        <= '0;
            idx      <= '0;
            cap      <= '0;
            idle_cnt <= '0;
            regsel   <= '0;
        end else begin
            state <= state_nx;
            case (state)
                ST_SEL: regsel <= k;
                ST_CAP: begin
                    cap <= regdat;
                    idx <= '0;
                end
                ST_EMIT: if (accept) begin
                    if (last_chr) begin
                        idx      <= '0;
                        idle_cnt <= '0;
                        k        <= (k == LAST_FIELD) ? 3'd0 : k + 3'd1;
                    end else begin
                        idx <= idx + 2'd1;
                    end
                end
                ST_IDLE: idle_cnt <= idle_cnt + 24'd1;
                default: ;
            endcase
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            ST_SEL:  state_nx = ST_CAP;
            ST_CAP:  state_nx = ST_EMIT;
            ST_EMIT: if (accept && last_chr)
                         state_nx = (k == LAST_FIELD) ? ST_IDLE : ST_SEL;
            ST_IDLE: if (idle_done) state_nx = ST_SEL;
            default: state_nx = ST_SEL;
        endcase
    end

    // Outputs decode from registered state only, so they hold while stalled.
    assign char_valid = (state == ST_EMIT);
    assign frame_done = (state == ST_IDLE) && (idle_cnt == 24'd0);

    assign line1     = (k >= LINE_SPLIT);
    assign slot      = line1 ? k - LINE_SPLIT : k;
    assign char_addr = (line1 ? LINE1_BASE : LINE0_BASE)
                     + 7'(slot) * 7'(FIELD_W) + 7'(idx);

    always_comb begin
        char_code = SPACE_CODE;
        if (state == ST_EMIT) begin
`ifdef TD4_DISP_LABEL_EN
            case (idx)
                2'd0:    char_code = label_char(k);
                2'd1:    char_code = hi_code;
                2'd2:    char_code = lo_code;
                default: char_code = SPACE_CODE;
            endcase
`else
            case (idx)
                2'd0:    char_code = hi_code;
                2'd1:    char_code = lo_code;
                default: char_code = SPACE_CODE;
            endcase
`endif
        end
    end

endmodule

// File: tb/tb_td4_reg_display.sv
// Directed bench for td4_reg_display: frame layout, backpressure, refresh and reset.
module tb_td4_reg_display;

`ifdef TD4_DISP_LABEL_EN
    localparam int NCH = 4;
`else
    localparam int NCH = 3;
`endif
    localparam int FW    = NCH + 2;
    localparam int FRAME = 6 * FW;
    localparam int S2    = FRAME + 4;
    localparam int E1    = S2 + FW + 2;
    localparam int F2    = E1 + NCH + 7;

    typedef struct {
        logic [2:0] fld;
        logic [7:0] val;
        logic [6:0] addr;
        logic [7:0] code;
    } vec_t;

    logic       CLOCK, RESET, char_valid, char_ready, frame_done;
    logic [2:0] regsel;
    logic [7:0] regdat, char_code;
    logic [6:0] char_addr;
    logic [7:0] regs [6];

    int n_cmp = 0;
    int n_bad = 0;
    vec_t tbl [NCH*6];

    assign regdat = (regsel < 3'd6) ? regs[regsel] : 8'h00;

    td4_reg_display #(.REFRESH_DIV(4)) dut (
        .CLOCK(CLOCK), .RESET(RESET), .regsel(regsel), .regdat(regdat),
        .char_valid(char_valid), .char_ready(char_ready),
        .char_addr(char_addr), .char_code(char_code), .frame_done(frame_done)
    );

    initial CLOCK = 1'b0;
    always #5 CLOCK = ~CLOCK;

    task automatic chk(input string nm, input int c, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s @cycle %0d: got %0h expected %0h", nm, c, act, exp);
        end
    endtask

    initial begin
        int n;
`ifdef TD4_DISP_LABEL_EN
        tbl[0]  = '{3'd0, 8'h14, 7'h00, 8'h50}; tbl[1]  = '{3'd0, 8'h14, 7'h01, 8'h31};
        tbl[2]  = '{3'd0, 8'h14, 7'h02, 8'h34}; tbl[3]  = '{3'd0, 8'h14, 7'h03, 8'h20};
        tbl[4]  = '{3'd1, 8'hAF, 7'h04, 8'h41}; tbl[5]  = '{3'd1, 8'hAF, 7'h05, 8'h41};
        tbl[6]  = '{3'd1, 8'hAF, 7'h06, 8'h46}; tbl[7]  = '{3'd1, 8'hAF, 7'h07, 8'h20};
        tbl[8]  = '{3'd2, 8'h5C, 7'h08, 8'h42}; tbl[9]  = '{3'd2, 8'h5C, 7'h09, 8'h35};
        tbl[10] = '{3'd2, 8'h5C, 7'h0A, 8'h43}; tbl[11] = '{3'd2, 8'h5C, 7'h0B, 8'h20};
        tbl[12] = '{3'd3, 8'h01, 7'h40, 8'h43}; tbl[13] = '{3'd3, 8'h01, 7'h41, 8'h30};
        tbl[14] = '{3'd3, 8'h01, 7'h42, 8'h31}; tbl[15] = '{3'd3, 8'h01, 7'h43, 8'h20};
        tbl[16] = '{3'd4, 8'h07, 7'h44, 8'h4F}; tbl[17] = '{3'd4, 8'h07, 7'h45, 8'h30};
        tbl[18] = '{3'd4, 8'h07, 7'h46, 8'h37}; tbl[19] = '{3'd4, 8'h07, 7'h47, 8'h20};
        tbl[20] = '{3'd5, 8'h85, 7'h48, 8'h49}; tbl[21] = '{3'd5, 8'h85, 7'h49, 8'h38};
        tbl[22] = '{3'd5, 8'h85, 7'h4A, 8'h35}; tbl[23] = '{3'd5, 8'h85, 7'h4B, 8'h20};
`else
        tbl[0]  = '{3'd0, 8'h14, 7'h00, 8'h31}; tbl[1]  = '{3'd0, 8'h14, 7'h01, 8'h34};
        tbl[2]  = '{3'd0, 8'h14, 7'h02, 8'h20};
        tbl[3]  = '{3'd1, 8'hAF, 7'h03, 8'h41}; tbl[4]  = '{3'd1, 8'hAF, 7'h04, 8'h46};
        tbl[5]  = '{3'd1, 8'hAF, 7'h05, 8'h20};
        tbl[6]  = '{3'd2, 8'h5C, 7'h06, 8'h35}; tbl[7]  = '{3'd2, 8'h5C, 7'h07, 8'h43};
        tbl[8]  = '{3'd2, 8'h5C, 7'h08, 8'h20};
        tbl[9]  = '{3'd3, 8'h01, 7'h40, 8'h30}; tbl[10] = '{3'd3, 8'h01, 7'h41, 8'h31};
        tbl[11] = '{3'd3, 8'h01, 7'h42, 8'h20};
        tbl[12] = '{3'd4, 8'h07, 7'h43, 8'h30}; tbl[13] = '{3'd4, 8'h07, 7'h44, 8'h37};
        tbl[14] = '{3'd4, 8'h07, 7'h45, 8'h20};
        tbl[15] = '{3'd5, 8'h85, 7'h46, 8'h38}; tbl[16] = '{3'd5, 8'h85, 7'h47, 8'h35};
        tbl[17] = '{3'd5, 8'h85, 7'h48, 8'h20};
`endif
        for (int i = 0; i < NCH*6; i++) regs[tbl[i].fld] = tbl[i].val;

        RESET = 1'b1;
        char_ready = 1'b1;
        repeat (3) @(posedge CLOCK);
        @(negedge CLOCK);
        chk("rst_regsel",     0, 32'(regsel),     32'h0);
        chk("rst_valid",      0, 32'(char_valid), 32'h0);
        chk("rst_addr",       0, 32'(char_addr),  32'h00);
        chk("rst_code",       0, 32'(char_code),  32'h20);
        chk("rst_frame_done", 0, 32'(frame_done), 32'h0);
        @(posedge CLOCK); #1;

        // Cycle c is the interval after the c-th edge following reset release.
        n = 0;
        for (int c = 0; c <= F2 + 5; c++) begin
            char_ready = !((c > E1 && c <= E1 + 5) || c == F2 + 1);
            RESET      = (c == F2 + 1);
            @(negedge CLOCK);

            chk("frame_done", c, 32'(frame_done), 32'(c == FRAME));
            if (c < S2 + 2)
                chk("valid_pattern", c, 32'(char_valid), 32'(c < FRAME && (c % FW) >= 2));
            if (c < FRAME && (c % FW) == 1)
                chk("cap_regsel", c, 32'(regsel), 32'(c / FW));
            if (c < FRAME && char_valid) begin
                if (n < NCH*6) begin
                    chk("wr_addr",  c, 32'(char_addr), 32'(tbl[n].addr));
                    chk("wr_code",  c, 32'(char_code), 32'(tbl[n].code));
                    chk("wr_cycle", c, 32'(c), 32'(FW*(n/NCH) + 2 + n%NCH));
                end
                n++;
            end
            if (c == FRAME) chk("frame_writes", c, 32'(n), 32'(NCH*6));
            if (c == S2 + 2) begin
                chk("refresh_valid", c, 32'(char_valid), 32'h1);
                chk("refresh_addr",  c, 32'(char_addr),  32'h00);
                chk("refresh_code",  c, 32'(char_code),  32'(tbl[0].code));
            end
            if (c == E1)
                chk("bp_first_addr", c, 32'(char_addr), 32'(tbl[NCH].addr));
            if (c > E1 && c <= E1 + 6) begin
                chk("bp_valid", c, 32'(char_valid), 32'h1);
                chk("bp_addr",  c, 32'(char_addr),  32'(tbl[NCH+1].addr));
                chk("bp_code",  c, 32'(char_code),  32'(tbl[NCH+1].code));
            end
            if (c == E1 + 7) begin
                chk("bp_next_addr", c, 32'(char_addr), 32'(tbl[NCH+2].addr));
                chk("bp_next_code", c, 32'(char_code), 32'(tbl[NCH+2].code));
            end
            if (c == F2 + 1) begin
                chk("pre_rst_valid",  c, 32'(char_valid), 32'h1);
                chk("pre_rst_regsel", c, 32'(regsel),     32'h2);
                chk("pre_rst_addr",   c, 32'(char_addr),  32'(tbl[2*NCH+1].addr));
            end
            if (c == F2 + 2) begin
                chk("rst_drop_valid", c, 32'(char_valid), 32'h0);
                chk("rst_regsel0",    c, 32'(regsel),     32'h0);
            end
            if (c == F2 + 3) chk("restart_cap_regsel", c, 32'(regsel), 32'h0);
            if (c == F2 + 4) begin
                chk("restart_valid", c, 32'(char_valid), 32'h1);
                chk("restart_addr",  c, 32'(char_addr),  32'(tbl[0].addr));
                chk("restart_code",  c, 32'(char_code),  32'(tbl[0].code));
            end
            @(posedge CLOCK); #1;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
